// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, optional parity and one stop bit, each Prescaler CLK cycles wide.
// Define UART_TX_HOLD_EN for a one-entry holding register (TX_Full) that chains frames with no idle gap.
module uart_tx #(
    parameter int Data_Width = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [Data_Width-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [4:0]            Prescaler,
    output logic                  TX_OUT,
`ifdef UART_TX_HOLD_EN
    output logic                  TX_Full,
`endif
    output logic                  Busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                  state_q, state_d;
    logic [4:0]              cnt_q, cnt_d;
    logic [2:0]              bit_q, bit_d;
    logic [Data_Width-1:0]   shift_q, shift_d;
    logic                    pen_q, pen_d;
    logic                    par_q, par_d;
    logic [4:0]              pre_q, pre_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;

    logic                    term;
    logic                    load;
    logic [Data_Width-1:0]   ld_data;
    logic                    ld_pen, ld_typ;
    logic [4:0]              ld_pre;

`ifdef UART_TX_HOLD_EN
    logic                    hfull_q, hfull_d;
    logic [Data_Width-1:0]   hdata_q, hdata_d;
    logic                    hpen_q, hpen_d;
    logic                    htyp_q, htyp_d;
    logic [4:0]              hpre_q, hpre_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pen_d   = pen_q;
        par_d   = par_q;
        pre_d   = pre_q;
        load    = 1'b0;
        ld_data = P_DATA;
        ld_pen  = PAR_EN;
        ld_typ  = PAR_TYP;
        ld_pre  = Prescaler;
        term    = (cnt_q == pre_q - 5'd1);
`ifdef UART_TX_HOLD_EN
        hfull_d = hfull_q;
        hdata_d = hdata_q;
        hpen_d  = hpen_q;
        htyp_d  = htyp_q;
        hpre_d  = hpre_q;
`endif

        if (state_q != IDLE) cnt_d = term ? 5'd0 : cnt_q + 5'd1;

        case (state_q)
            IDLE:   if (Data_Valid) load = 1'b1;
            START:  if (term) state_d = DATA;
            DATA: begin
                if (term) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'(Data_Width - 1)) begin
                        bit_d   = 3'd0;
                        state_d = pen_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            PARITY: if (term) state_d = STOP;
            STOP: begin
                if (term) begin
                    state_d = IDLE;
`ifdef UART_TX_HOLD_EN
                    // A pending word launches straight from STOP; otherwise a request
                    // arriving right on the boundary is taken directly instead of held.
                    if (hfull_q) begin
                        load    = 1'b1;
                        ld_data = hdata_q;
                        ld_pen  = hpen_q;
                        ld_typ  = htyp_q;
                        ld_pre  = hpre_q;
                        hfull_d = 1'b0;
                    end else if (Data_Valid) begin
                        load = 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef UART_TX_HOLD_EN
        if (state_q != IDLE && !(state_q == STOP && term) && Data_Valid && !hfull_q) begin
            hfull_d = 1'b1;
            hdata_d = P_DATA;
            hpen_d  = PAR_EN;
            htyp_d  = PAR_TYP;
            hpre_d  = Prescaler;
        end
`endif

        if (load) begin
            state_d = START;
            cnt_d   = 5'd0;
            bit_d   = 3'd0;
            shift_d = ld_data;
            pen_d   = ld_pen;
            par_d   = (^ld_data) ^ ld_typ;
            pre_d   = (ld_pre < 5'd2) ? 5'd2 : ld_pre;
        end

        // Line level is registered from the next state so TX_OUT is a pure flop.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            pen_q   <= 1'b0;
            par_q   <= 1'b0;
            pre_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            pen_q   <= pen_d;
            par_q   <= par_d;
            pre_q   <= pre_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

`ifdef UART_TX_HOLD_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hfull_q <= 1'b0;
            hdata_q <= '0;
            hpen_q  <= 1'b0;
            htyp_q  <= 1'b0;
            hpre_q  <= '0;
        end else begin
            hfull_q <= hfull_d;
            hdata_q <= hdata_d;
            hpen_q  <= hpen_d;
            htyp_q  <= htyp_d;
            hpre_q  <= hpre_d;
        end
    end

    assign TX_Full = hfull_q;
`endif

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-level queue model checked every cycle, plus literal bit/length pins.
module tb_uart_tx;
    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [DW-1:0] P_DATA = '0;
    logic          Data_Valid = 1'b0;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic [4:0]    Prescaler = 5'd2;
    logic          TX_OUT, Busy;
`ifdef UART_TX_HOLD_EN
    logic          TX_Full;
`endif

    int total = 0;
    int bad = 0;

    uart_tx #(.Data_Width(DW)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .Prescaler(Prescaler),
        .TX_OUT(TX_OUT),
`ifdef UART_TX_HOLD_EN
        .TX_Full(TX_Full),
`endif
        .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame becomes a queue of per-cycle line levels; Busy is high while a frame is shown.
    bit            exp_q[$];
    logic          m_tx = 1'b1;
    logic          m_busy = 1'b0;
    logic          m_full = 1'b0;
    logic [DW-1:0] m_hdata;
    logic          m_hpen, m_htyp;
    logic [4:0]    m_hpre;

    function automatic void push_frame(input logic [DW-1:0] d, input logic pen,
                                       input logic typ, input logic [4:0] pre);
        int p;
        bit b[$];
        p = (pre < 2) ? 2 : int'(pre);
        b.push_back(1'b0);
        for (int i = 0; i < DW; i++) b.push_back(d[i]);
        if (pen) b.push_back((^d) ^ typ);
        b.push_back(1'b1);
        foreach (b[i]) repeat (p) exp_q.push_back(b[i]);
    endfunction

    initial forever begin
        @(posedge CLK or negedge RST);
        if (!RST) begin
            exp_q.delete();
            m_tx = 1'b1; m_busy = 1'b0; m_full = 1'b0;
        end else if (exp_q.size() > 0) begin
            m_tx = exp_q.pop_front(); m_busy = 1'b1;
`ifdef UART_TX_HOLD_EN
            if (Data_Valid && !m_full) begin
                m_full = 1'b1; m_hdata = P_DATA; m_hpen = PAR_EN; m_htyp = PAR_TYP; m_hpre = Prescaler;
            end
`endif
        end else if (m_busy) begin
            bit launched;
            launched = 1'b0;
`ifdef UART_TX_HOLD_EN
            if (m_full) begin
                push_frame(m_hdata, m_hpen, m_htyp, m_hpre); m_full = 1'b0; launched = 1'b1;
            end else if (Data_Valid) begin
                push_frame(P_DATA, PAR_EN, PAR_TYP, Prescaler); launched = 1'b1;
            end
`endif
            if (launched) m_tx = exp_q.pop_front();
            else begin m_tx = 1'b1; m_busy = 1'b0; end
        end else if (Data_Valid) begin
            push_frame(P_DATA, PAR_EN, PAR_TYP, Prescaler);
            m_tx = exp_q.pop_front(); m_busy = 1'b1;
        end
    end

    initial forever begin
        @(negedge CLK);
        if (RST) begin
            check("tx_vs_model", TX_OUT, m_tx);
            check("busy_vs_model", Busy, m_busy);
`ifdef UART_TX_HOLD_EN
            check("full_vs_model", TX_Full, m_full);
`endif
        end
    end

    // Called at a negedge; leaves Data_Valid low at the negedge after the acceptance edge.
    task automatic send(input logic [DW-1:0] d, input logic pen, input logic typ, input logic [4:0] pre);
        P_DATA = d; PAR_EN = pen; PAR_TYP = typ; Prescaler = pre; Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
    endtask

    // Samples the line mid-bit like a receiver would and measures the Busy window.
    task automatic run_frame(input string tag, input int pre_eff, input int nbits,
                             input logic [15:0] exp_bits, input int exp_len, input bit scramble);
        logic [15:0] got, mask;
        int cyc;
        got = '0; cyc = 0;
        mask = 16'((32'd1 << nbits) - 1);
        while (Busy && cyc < 1000) begin
            if ((cyc % pre_eff) == pre_eff / 2 && (cyc / pre_eff) < 16) got[cyc / pre_eff] = TX_OUT;
            if (scramble && cyc == 3) begin
                P_DATA = ~P_DATA; PAR_EN = ~PAR_EN; PAR_TYP = ~PAR_TYP; Prescaler = 5'd3;
            end
            cyc++;
            @(negedge CLK);
        end
        check({tag, "_bits"}, 32'(got & mask), 32'(exp_bits));
        check({tag, "_len"}, cyc, exp_len);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (Busy && n < 2000) begin n++; @(negedge CLK); end
        check({tag, "_idle_timeout"}, Busy, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check("reset_tx", TX_OUT, 1'b1);
        check("reset_busy", Busy, 1'b0);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        send(8'hA5, 1'b1, 1'b0, 5'd8);
        run_frame("even_a5", 8, 11, {1'b1, 1'b0, 8'hA5, 1'b0}, 88, 1'b0);
        @(negedge CLK);

        send(8'h01, 1'b1, 1'b1, 5'd16);
        run_frame("odd_01", 16, 11, {1'b1, 1'b0, 8'h01, 1'b0}, 176, 1'b0);
        @(negedge CLK);

        send(8'h01, 1'b1, 1'b0, 5'd16);
        run_frame("even_01_scr", 16, 11, {1'b1, 1'b1, 8'h01, 1'b0}, 176, 1'b1);
        @(negedge CLK);

        send(8'hFF, 1'b0, 1'b0, 5'd31);
        run_frame("nopar_ff", 31, 10, {1'b1, 8'hFF, 1'b0}, 310, 1'b0);
        @(negedge CLK);

        send(8'h5A, 1'b0, 1'b0, 5'd0);
        run_frame("clamp0", 2, 10, {1'b1, 8'h5A, 1'b0}, 20, 1'b0);
        send(8'hC3, 1'b0, 1'b1, 5'd1);
        run_frame("clamp1", 2, 10, {1'b1, 8'hC3, 1'b0}, 20, 1'b0);

        // Request during a frame, then a back-to-back request in the first idle cycle.
        send(8'h96, 1'b1, 1'b1, 5'd4);
        repeat (10) @(negedge CLK);
        send(8'h3C, 1'b0, 1'b1, 5'd9);
        wait_idle("ignore");
        send(8'h3C, 1'b1, 1'b0, 5'd4);
        check("b2b_start", TX_OUT, 1'b0);
        run_frame("loop_3c", 4, 11, {1'b1, 1'b0, 8'h3C, 1'b0}, 44, 1'b0);

        // Asynchronous reset in the middle of a frame.
        send(8'hA5, 1'b1, 1'b0, 5'd8);
        repeat (20) @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        check("async_rst_tx", TX_OUT, 1'b1);
        check("async_rst_busy", Busy, 1'b0);
        @(negedge CLK);
        #2 RST = 1'b1;
        repeat (30) @(negedge CLK);
        check("post_rst_busy", Busy, 1'b0);
        check("post_rst_tx", TX_OUT, 1'b1);

`ifdef UART_TX_HOLD_EN
        send(8'h11, 1'b0, 1'b0, 5'd4);
        repeat (5) @(negedge CLK);
        send(8'h22, 1'b1, 1'b0, 5'd4);
        check("hold_full", TX_Full, 1'b1);
        send(8'h33, 1'b0, 1'b0, 5'd4);
        wait_idle("hold");
        check("hold_full_clear", TX_Full, 1'b0);
`endif

        repeat (5) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter, the transmit-side counterpart of the oversampling UART receiver, clocked on the same CLK.
- Accepts a parallel word on a valid strobe.
- Serialises it LSB-first as start bit, data bits, optional parity bit and one stop bit.
- Each bit is held for Prescaler CLK cycles, so TX and RX share one clock and one prescaler setting.
- Sits between the system-side producer and the serial line pin.

Parameters:
Data_Width, 8, number of data bits per frame (legal 5..8).

Ports:
CLK  input  1  system/oversampling clock, rising edge.
RST  input  1  asynchronous active-low reset.
P_DATA  input  Data_Width  parallel word to send.
Data_Valid  input  1  single-cycle request; accepted only when Busy=0.
PAR_EN  input  1  1 = parity bit inserted after data.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
Prescaler  input  5  CLK cycles per bit (legal 2..31).
TX_OUT  output  1  serial line, idle high, registered.
Busy  output  1  high from the cycle after acceptance until the stop bit completes.

Behaviour:
- Reset (RST=0, async): TX_OUT=1, Busy=0, FSM=IDLE, all counters 0, shift/config registers 0. Release is synchronous to the next CLK edge.
- States: IDLE, START, DATA, PARITY, STOP.
- Acceptance, IDLE with Data_Valid=1 at edge n:
  - Latch P_DATA, PAR_EN, PAR_TYP and Prescaler. Values below 2 are latched as 2.
  - Compute the parity bit: even = XOR of data bits; odd = its inverse.
  - Go to START. From cycle n+1: TX_OUT=0, Busy=1.
- Bit timing:
  - A 5-bit edge counter runs 0..Prescaler_latched-1 in every non-IDLE state.
  - On the terminal count the FSM advances; otherwise the state holds.
  - Every bit is exactly Prescaler_latched cycles wide.
- Serial sequence:
  - START drives 0.
  - DATA drives shift-register bit 0 and shifts right on each bit boundary. A 3-bit bit counter counts 0..Data_Width-1. On the last data bit the FSM goes to PARITY if PAR_EN latched = 1, else STOP.
  - PARITY drives the latched parity bit.
  - STOP drives 1. At its terminal count the FSM goes to IDLE and Busy drops to 0 in that same cycle.
- Frame length: (1 + Data_Width + PAR_EN + 1) × Prescaler cycles, start-bit first cycle to stop-bit last cycle.
- Back-to-back: Data_Valid in the first IDLE cycle after STOP is accepted. Line-high time between frames is therefore ≥ Prescaler+1 cycles.
- Data_Valid while Busy=1: ignored, no effect on the frame in flight (base build).
- Changes to P_DATA, PAR_EN, PAR_TYP or Prescaler mid-frame: no effect, because all are latched at acceptance.
- TX_OUT is a flop output; there is no combinational path from any input to TX_OUT.
- Reset mid-frame: TX_OUT returns to 1 immediately and the frame is abandoned. No resume after release.

Optional Feature:
Macro UART_TX_HOLD_EN.
- With the macro: adds a one-entry holding register and an output port TX_Full (1 bit, reset 0).
  - Data_Valid with Busy=1 and TX_Full=0 captures P_DATA, PAR_EN, PAR_TYP and Prescaler into the hold register; TX_Full=1 from the next cycle.
  - When STOP completes with TX_Full=1, the FSM goes directly STOP→START, loading from the hold register with no idle cycle. TX_Full clears in that cycle and Busy stays 1.
  - Data_Valid with TX_Full=1 is ignored.
  - Data_Valid in IDLE behaves as in the base build.
- Without the macro: no hold register, no TX_Full port; behaviour as above.

Test Plan:
- Reset: RST=0 mid-frame for 1 cycle → TX_OUT=1 and Busy=0 without waiting for a CLK edge; no further activity after release.
- Even parity: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, Prescaler=8 →
  - TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 8 cycles.
  - Busy high exactly 88 cycles.
- Odd parity: P_DATA=0x01, PAR_EN=1, PAR_TYP=1, Prescaler=16 → parity bit 0, frame 176 cycles. Repeat with PAR_TYP=0 → parity bit 1.
- No parity: P_DATA=0xFF, PAR_EN=0, Prescaler=31 → 0 followed by nine 1s, frame 310 cycles.
- Busy ignore and back-to-back:
  - Pulse Data_Valid with 0x3C while Busy=1 → no effect on the current frame.
  - Pulse Data_Valid in the first IDLE cycle with 0x3C → next start bit begins the following cycle.
  - Loopback into the receiver with the same Prescaler and PAR settings → receiver reports Data_Valid with P_Data=0x3C and no errors.
- UART_TX_HOLD_EN: send 0x11, then 0x22 during the 0x11 frame → TX_Full=1; 0x22 start bit immediately follows the 0x11 stop bit; a third request while TX_Full=1 is dropped.
